// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read port (M_) between two requesters (S0_, S1_).
// One burst is outstanding at a time. Address-phase fields are latched at grant, and
// data beats are routed only to the granted requester.
// Optional macro ARB_FIXED_PRIO_EN: S0 always wins ties (no round-robin state).
module axi_rd_arbiter #(
  parameter int WIDTH_ID = 2,
  parameter int WIDTH_DA = 32,
  parameter int WIDTH_AD = 32
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESET,
  // requester 0
  input  logic [WIDTH_ID-1:0] S0_AXI_ARID,
  input  logic [WIDTH_AD-1:0] S0_AXI_ARADDR,
  input  logic [3:0]          S0_AXI_ARLEN,
  input  logic [2:0]          S0_AXI_ARSIZE,
  input  logic [1:0]          S0_AXI_ARBURST,
  input  logic                S0_AXI_ARVALID,
  output logic                S0_AXI_ARREADY,
  output logic [WIDTH_ID-1:0] S0_AXI_RID,
  output logic [WIDTH_DA-1:0] S0_AXI_RDATA,
  output logic [1:0]          S0_AXI_RRESP,
  output logic                S0_AXI_RLAST,
  output logic                S0_AXI_RVALID,
  input  logic                S0_AXI_RREADY,
  // requester 1
  input  logic [WIDTH_ID-1:0] S1_AXI_ARID,
  input  logic [WIDTH_AD-1:0] S1_AXI_ARADDR,
  input  logic [3:0]          S1_AXI_ARLEN,
  input  logic [2:0]          S1_AXI_ARSIZE,
  input  logic [1:0]          S1_AXI_ARBURST,
  input  logic                S1_AXI_ARVALID,
  output logic                S1_AXI_ARREADY,
  output logic [WIDTH_ID-1:0] S1_AXI_RID,
  output logic [WIDTH_DA-1:0] S1_AXI_RDATA,
  output logic [1:0]          S1_AXI_RRESP,
  output logic                S1_AXI_RLAST,
  output logic                S1_AXI_RVALID,
  input  logic                S1_AXI_RREADY,
  // memory side
  output logic [WIDTH_ID-1:0] M_AXI_ARID,
  output logic [WIDTH_AD-1:0] M_AXI_ARADDR,
  output logic [3:0]          M_AXI_ARLEN,
  output logic [2:0]          M_AXI_ARSIZE,
  output logic [1:0]          M_AXI_ARBURST,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [WIDTH_ID-1:0] M_AXI_RID,
  input  logic [WIDTH_DA-1:0] M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RLAST,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t              state_q, state_d;
  logic                grant_q;
  logic [WIDTH_ID-1:0] arid_q;
  logic [WIDTH_AD-1:0] araddr_q;
  logic [3:0]          arlen_q;
  logic [2:0]          arsize_q;
  logic [1:0]          arburst_q;
  logic                win;
  logic                ar_hs;
  logic                sel0, sel1;
  logic                burst_end;

  // Returned RID is replaced by the latched ARID, so the memory-side RID is not needed.
  logic unused_rid;
  assign unused_rid = ^M_AXI_RID;

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: S0 wins whenever it is requesting.
  always_comb begin
    win = S0_AXI_ARVALID ? 1'b0 : 1'b1;
  end
`else
  logic last_grant_q;

  // Round-robin: on a tie the port that was not served last wins.
  always_comb begin
    win = 1'b1;
    if (S0_AXI_ARVALID && S1_AXI_ARVALID) win = ~last_grant_q;
    else if (S0_AXI_ARVALID)              win = 1'b0;
    else                                  win = 1'b1;
  end

  // Remember who was served last; updated only when a burst completes.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET)   last_grant_q <= 1'b1;
    else if (burst_end) last_grant_q <= grant_q;
  end
`endif

  // Reset is also gated in here so no ARREADY is visible while reset is held.
  assign ar_hs          = (state_q == IDLE) && !S_AXI_ARESET && (S0_AXI_ARVALID || S1_AXI_ARVALID);
  assign S0_AXI_ARREADY = ar_hs && !win;
  assign S1_AXI_ARREADY = ar_hs && win;
  assign burst_end      = (state_q == DATA) && M_AXI_RVALID && M_AXI_RREADY && M_AXI_RLAST;

  // Next-state logic: IDLE -> ADDR on grant, ADDR -> DATA on memory accept, DATA -> IDLE on RLAST.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ar_hs)         state_d = ADDR;
      ADDR:    if (M_AXI_ARREADY) state_d = DATA;
      DATA:    if (burst_end)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Capture grant and the winner's address-phase fields at the requester handshake.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      grant_q   <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else if (ar_hs) begin
      grant_q   <= win;
      arid_q    <= win ? S1_AXI_ARID    : S0_AXI_ARID;
      araddr_q  <= win ? S1_AXI_ARADDR  : S0_AXI_ARADDR;
      arlen_q   <= win ? S1_AXI_ARLEN   : S0_AXI_ARLEN;
      arsize_q  <= win ? S1_AXI_ARSIZE  : S0_AXI_ARSIZE;
      arburst_q <= win ? S1_AXI_ARBURST : S0_AXI_ARBURST;
    end
  end

  assign M_AXI_ARVALID = (state_q == ADDR);
  assign M_AXI_ARID    = arid_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = arlen_q;
  assign M_AXI_ARSIZE  = arsize_q;
  assign M_AXI_ARBURST = arburst_q;

  // Data routing: only the granted port sees the return channel, and only in DATA.
  assign sel0 = (state_q == DATA) && !grant_q;
  assign sel1 = (state_q == DATA) && grant_q;

  assign M_AXI_RREADY  = (sel0 && S0_AXI_RREADY) || (sel1 && S1_AXI_RREADY);

  assign S0_AXI_RVALID = sel0 && M_AXI_RVALID;
  assign S0_AXI_RLAST  = sel0 && M_AXI_RLAST;
  assign S0_AXI_RDATA  = sel0 ? M_AXI_RDATA : '0;
  assign S0_AXI_RRESP  = sel0 ? M_AXI_RRESP : '0;
  assign S0_AXI_RID    = sel0 ? arid_q      : '0;

  assign S1_AXI_RVALID = sel1 && M_AXI_RVALID;
  assign S1_AXI_RLAST  = sel1 && M_AXI_RLAST;
  assign S1_AXI_RDATA  = sel1 ? M_AXI_RDATA : '0;
  assign S1_AXI_RRESP  = sel1 ? M_AXI_RRESP : '0;
  assign S1_AXI_RID    = sel1 ? arid_q      : '0;

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH_ID, 2, AXI ID width; WIDTH_DA, 32, data width; WIDTH_AD, 32, address width.
REQ-002 S_AXI_ACLK  in  1  single clock; all logic on its rising edge.
REQ-003 S_AXI_ARESET  in  1  asynchronous, active-high reset.
REQ-004 Each line below lists one read-channel signal: requester ports S0_/S1_ first, then the memory-side port M_.
REQ-005 AXI_ARID  S0/S1 in, M out  WIDTH_ID  read ID.
REQ-006 AXI_ARADDR  S0/S1 in, M out  WIDTH_AD  read address.
REQ-007 AXI_ARLEN  S0/S1 in, M out  4  beats minus one.
REQ-008 AXI_ARSIZE  S0/S1 in, M out  3  beat size.
REQ-009 AXI_ARBURST  S0/S1 in, M out  2  burst type.
REQ-010 AXI_ARVALID  S0/S1 in, M out  1  address valid.
REQ-011 AXI_ARREADY  S0/S1 out, M in  1  address ready.
REQ-012 AXI_RID  S0/S1 out, M in  WIDTH_ID  read ID.
REQ-013 AXI_RDATA  S0/S1 out, M in  WIDTH_DA  read data.
REQ-014 AXI_RRESP  S0/S1 out, M in  2  read response.
REQ-015 AXI_RLAST  S0/S1 out, M in  1  last beat.
REQ-016 AXI_RVALID  S0/S1 out, M in  1  data valid.
REQ-017 AXI_RREADY  S0/S1 in, M out  1  data ready.

Function
REQ-018 The block SHALL share one memory read port between two requesters, with exactly one burst outstanding at a time.
REQ-019 FSM states SHALL be IDLE, ADDR and DATA.
REQ-020 IDLE: the winner is computed combinationally from S0/S1_ARVALID; only the winner's ARREADY is 1; all other ARREADY are 0.
REQ-021 IDLE, on winner ARVALID&ARREADY: latch grant and ARID/ARADDR/ARLEN/ARSIZE/ARBURST; go to ADDR.
REQ-022 ADDR: M_AXI_ARVALID=1 with the latched fields, held stable until M_AXI_ARREADY=1; then go to DATA.
REQ-023 Latency: requester handshake in cycle N gives M_AXI_ARVALID=1 in cycle N+1.
REQ-024 DATA: the granted port gets M RDATA/RRESP/RLAST/RVALID combinationally, and M_AXI_RREADY = granted RREADY.
REQ-025 DATA: granted RID SHALL be the latched ARID, not M_AXI_RID.
REQ-026 DATA: the non-granted port has RVALID=0; its RREADY is ignored.
REQ-027 DATA, on M RVALID&RREADY&RLAST: go to IDLE and update last_grant.
REQ-028 A new grant SHALL NOT be issued in the cycle the burst ends; the earliest next requester ARREADY is the following cycle.
REQ-029 Round-robin: when both requesters are valid, the port not in last_grant wins; when one is valid, it wins.
REQ-030 ARVALID deasserted before the handshake SHALL NOT produce a grant.
REQ-031 M_AXI_RVALID outside DATA SHALL be ignored and never forwarded.
REQ-032 No bursts are counted; only RLAST ends DATA.

Reset
REQ-033 Asserting S_AXI_ARESET at any time, including mid-burst, SHALL immediately force IDLE.
REQ-034 Reset values: last_grant=1 (S0 wins first); all ARREADY, ARVALID, RVALID, RLAST and RREADY outputs 0; latched fields 0.
REQ-035 A burst interrupted by reset SHALL be abandoned; no beats are forwarded after reset release.

Configuration
REQ-036 Macro ARB_FIXED_PRIO_EN: when defined, S0 SHALL always win ties and last_grant is unused.
REQ-037 When ARB_FIXED_PRIO_EN is not defined, round-robin per REQ-029 applies.

Verification
REQ-038 S0 only, ARADDR=0x10, ARLEN=3 -> M_ARVALID next cycle with addr 0x10; 4 beats routed to S0 with RLAST on beat 4; S1_RVALID stays 0.
REQ-039 S0 and S1 both valid from reset -> order S0, S1, S0, S1 over 4 bursts; with ARB_FIXED_PRIO_EN: S0 four times while S0 stays valid.
REQ-040 S1_ARID=2, memory returns RID=0 -> S1_RID=2 on all 4 beats.
REQ-041 Granted RREADY held 0 for 3 cycles mid-burst -> M_RREADY=0 and RDATA held; no beat lost or duplicated.
REQ-042 Reset asserted at beat 2 of an S0 burst -> outputs 0 in the same cycle; after release, S1 request served first burst cleanly.
REQ-043 M_ARREADY held 0 for 5 cycles -> M_ARVALID and M_ARADDR stable; requester ARREADY stays 0 throughout.
